// File: rtl/sd_cmd_framer.sv
// rtl/sd_cmd_framer.sv - SD SPI command framer: CRC7 build, byte push, R1 poll, trailing fill byte
module sd_cmd_framer #(
    parameter int unsigned RESP_POLL_MAX = 8,
    parameter logic [7:0]  FILL_BYTE     = 8'hFF
) (
    input  logic        CLK50,
    input  logic        RST,
    input  logic        CMD_STB,
    input  logic [5:0]  CMD_IDX,
    input  logic [31:0] CMD_ARG,
    output logic        CMD_BUSY,
    output logic        RESP_VALID,
    output logic [7:0]  RESP_R1,
    output logic        RESP_TIMEOUT,
    output logic        CS_N,
    output logic        BYTE_REQ,
    output logic [7:0]  BYTE_TX,
    input  logic        BYTE_DONE,
    input  logic [7:0]  BYTE_RX
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_POLL  = 3'd3;
    localparam logic [2:0] S_TRAIL = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [7:0] POLL_LAST = 8'(RESP_POLL_MAX - 1);

    logic [2:0]  state_q,    state_d;
    logic [39:0] frame_q,    frame_d;
    logic [6:0]  crc_q,      crc_d;
    logic [5:0]  bit_cnt_q,  bit_cnt_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  poll_cnt_q, poll_cnt_d;
    logic        req_q,      req_d;
    logic        pend_q,     pend_d;
    logic [7:0]  tx_q,       tx_d;
    logic        cs_n_q,     cs_n_d;
    logic [7:0]  r1_q,       r1_d;
    logic        tmo_q,      tmo_d;
    logic        done_ok;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [39:0] f,
                                              input logic [6:0] c);
        logic [7:0] b;
        case (idx)
            3'd0:    b = f[39:32];
            3'd1:    b = f[31:24];
            3'd2:    b = f[23:16];
            3'd3:    b = f[15:8];
            3'd4:    b = f[7:0];
            default: b = {c, 1'b1};
        endcase
        return b;
    endfunction

    // A completion only counts once its request pulse has gone by.
    assign done_ok = BYTE_DONE & pend_q & ~req_q;

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        crc_d      = crc_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        poll_cnt_d = poll_cnt_q;
        req_d      = 1'b0;
        pend_d     = pend_q;
        tx_d       = tx_q;
        cs_n_d     = cs_n_q;
        r1_d       = r1_q;
        tmo_d      = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (CMD_STB) begin
                    frame_d    = {2'b01, CMD_IDX, CMD_ARG};
                    crc_d      = 7'd0;
                    bit_cnt_d  = 6'd0;
                    byte_idx_d = 3'd0;
                    poll_cnt_d = 8'd0;
                    cs_n_d     = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                crc_d     = crc7_step(crc_q, frame_q[6'd39 - bit_cnt_q]);
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'd39) begin
                    req_d   = 1'b1;
                    pend_d  = 1'b1;
                    tx_d    = frame_q[39:32];
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (done_ok) begin
                    req_d = 1'b1;
                    if (byte_idx_q == 3'd5) begin
                        tx_d    = FILL_BYTE;
                        state_d = S_POLL;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        tx_d       = frame_byte(byte_idx_q + 3'd1, frame_q, crc_q);
                    end
                end
            end
            S_POLL: begin
                if (done_ok) begin
                    req_d      = 1'b1;
                    tx_d       = FILL_BYTE;
                    poll_cnt_d = poll_cnt_q + 8'd1;
                    if (!BYTE_RX[7]) begin
                        r1_d    = BYTE_RX;
                        tmo_d   = 1'b0;
                        state_d = S_TRAIL;
                    end else if (poll_cnt_q == POLL_LAST) begin
                        r1_d    = 8'hFF;
                        tmo_d   = 1'b1;
                        state_d = S_TRAIL;
                    end
                end
            end
            S_TRAIL: begin
                if (done_ok) begin
                    pend_d  = 1'b0;
                    cs_n_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            crc_q      <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            poll_cnt_q <= '0;
            req_q      <= 1'b0;
            pend_q     <= 1'b0;
            tx_q       <= 8'hFF;
            cs_n_q     <= 1'b1;
            r1_q       <= 8'hFF;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            crc_q      <= crc_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            poll_cnt_q <= poll_cnt_d;
            req_q      <= req_d;
            pend_q     <= pend_d;
            tx_q       <= tx_d;
            cs_n_q     <= cs_n_d;
            r1_q       <= r1_d;
            tmo_q      <= tmo_d;
        end
    end

    assign CS_N         = cs_n_q;
    assign BYTE_REQ     = req_q;
    assign BYTE_TX      = tx_q;
    assign RESP_R1      = r1_q;
    assign RESP_TIMEOUT = tmo_q;
    assign CMD_BUSY     = (state_q != S_IDLE);
    assign RESP_VALID   = (state_q == S_DONE);

endmodule

// File: doc/sd_cmd_framer.md
Name: sd_cmd_framer

Overview:
Command-layer sequencer that sits directly upstream of the SPI byte engine driving the microSD card. It accepts a command index and a 32-bit argument, then builds the 6-byte SD SPI frame including CRC7. It pushes the frame one byte at a time through a request/done byte handshake, polls for the R1 response, clocks one trailing fill byte, and then reports R1 or a timeout to the controlling logic.

Parameters:
RESP_POLL_MAX, 8, maximum number of 0xFF poll bytes sent while waiting for R1 (1..255)
FILL_BYTE, 8'hFF, byte transmitted during poll and trailing phases

Ports:
CLK50  input  1  system clock, 50 MHz, all logic on rising edge
RST  input  1  asynchronous, active-high reset
CMD_STB  input  1  one-cycle start pulse; CMD_IDX/CMD_ARG sampled on the same cycle
CMD_IDX  input  6  SD command index
CMD_ARG  input  32  command argument, MSB sent first
CMD_BUSY  output  1  high from the cycle after an accepted CMD_STB until the RESP_VALID cycle inclusive
RESP_VALID  output  1  one-cycle pulse; RESP_R1 and RESP_TIMEOUT valid on this cycle and held until the next accepted command
RESP_R1  output  8  captured R1 byte (0xFF on timeout)
RESP_TIMEOUT  output  1  set if no R1 arrived within RESP_POLL_MAX bytes
CS_N  output  1  card chip select, active low
BYTE_REQ  output  1  one-cycle pulse requesting one byte exchange
BYTE_TX  output  8  byte to send; stable from BYTE_REQ until BYTE_DONE
BYTE_DONE  input  1  one-cycle pulse from byte engine when the exchange is complete
BYTE_RX  input  8  byte received; sampled only on the BYTE_DONE cycle

Behaviour:
- Reset is asynchronous, active-high, clock CLK50. Reset values: CS_N=1, BYTE_REQ=0, BYTE_TX=0xFF, CMD_BUSY=0, RESP_VALID=0, RESP_R1=0xFF, RESP_TIMEOUT=0, state=IDLE.
- States: IDLE, LOAD, SEND, POLL, TRAIL, DONE.
- IDLE: CMD_STB=1 latches the frame {2'b01, CMD_IDX, CMD_ARG} (40 bits), clears the CRC register, and moves to LOAD. CMD_BUSY=1 and CS_N=0 from the next cycle. CMD_STB in any other state is ignored.
- LOAD: CRC7 uses polynomial x^7+x^3+1, with the 40 frame bits shifted in MSB first. One bit per cycle, exactly 40 cycles. Byte 5 = {crc7, 1'b1}.
- SEND: sends bytes 0..5 in order. Each byte costs one BYTE_REQ pulse, then a wait for BYTE_DONE. The next BYTE_REQ comes no earlier than the cycle after BYTE_DONE. The first BYTE_REQ occurs exactly 41 cycles after the CMD_STB cycle. After the 6th BYTE_DONE, go to POLL.
- POLL: sends FILL_BYTE per exchange.
  - If a BYTE_DONE has BYTE_RX[7]=0, capture RESP_R1=BYTE_RX, set RESP_TIMEOUT=0, go to TRAIL.
  - The poll counter is 8 bits and counts completed poll bytes. If RESP_POLL_MAX bytes complete with BYTE_RX[7]=1, set RESP_R1=0xFF, RESP_TIMEOUT=1, go to TRAIL.
  - An R1 on exactly the RESP_POLL_MAX-th byte is a success, not a timeout.
- TRAIL: one FILL_BYTE exchange with CS_N still low. On its BYTE_DONE, drive CS_N=1 and go to DONE.
- DONE: RESP_VALID=1 for one cycle, then IDLE. CMD_BUSY drops the cycle after DONE. A CMD_STB on that following IDLE cycle is accepted.
- BYTE_DONE arriving while no request is outstanding (IDLE, LOAD, DONE, or the BYTE_REQ cycle itself) is ignored; BYTE_RX is not sampled.
- At most one outstanding request at any time. BYTE_TX changes only on the cycle BYTE_REQ is asserted.
- Reset mid-operation: immediate return to reset values, no further BYTE_REQ, CS_N high. The byte engine shares the same RST.
- No internal timeout on BYTE_DONE: the framer waits indefinitely in SEND/POLL/TRAIL.

Test Plan:
- CMD_STB, IDX=0, ARG=0x00000000, byte engine returns 0xFF then 0x01 -> BYTE_TX sequence 40 00 00 00 00 95 FF FF FF; RESP_R1=0x01, RESP_TIMEOUT=0, one RESP_VALID pulse, CS_N high after the 9th BYTE_DONE.
- IDX=8, ARG=0x000001AA, R1 on 1st poll byte = 0x01 -> frame 48 00 00 01 AA 87, then exactly one poll byte and one trail byte; first BYTE_REQ 41 cycles after CMD_STB.
- IDX=55, ARG=0, BYTE_RX always 0xFF -> exactly 8 poll bytes, RESP_R1=0xFF, RESP_TIMEOUT=1. Repeat with R1=0x00 on the 8th poll byte -> success, RESP_TIMEOUT=0.
- Second CMD_STB during SEND, plus spurious BYTE_DONE pulses in LOAD -> no new frame, byte count unchanged, and the result matches the single-command case.
- RST asserted after the 3rd BYTE_DONE of SEND -> CS_N=1, BYTE_REQ=0, CMD_BUSY=0 immediately; a new CMD0 after release produces a clean full frame.
- Back-to-back commands, with CMD_STB on the first IDLE cycle after RESP_VALID -> accepted; CS_N high for at least 1 cycle between frames.
